// File: rtl/sobel_window_3x3_pkg.sv
// Shared types and sizing helpers for the 3x3 sobel window generator.
package sobel_win_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 9;

  // Counter width for a dimension; the lower bound keeps tiny sizes legal.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // p4 (the centre pixel) is deliberately absent.
  typedef struct packed {
    logic [WIN_W-1:0] p0;
    logic [WIN_W-1:0] p1;
    logic [WIN_W-1:0] p2;
    logic [WIN_W-1:0] p3;
    logic [WIN_W-1:0] p5;
    logic [WIN_W-1:0] p6;
    logic [WIN_W-1:0] p7;
    logic [WIN_W-1:0] p8;
  } win_t;

endpackage

// File: rtl/sobel_window_3x3_if.sv
// Pixel-in / window-out bus of the sobel window generator.
// in_sof exists only when SOBEL_WIN_SOF_EN is defined.
//
// Handshake: a beat moves on a rising clk edge where valid & ready are both
// high; valid and its payload hold steady until that edge, and ready may
// depend combinationally on the receiver's own state.
interface sobel_win_if;
  import sobel_win_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
`ifdef SOBEL_WIN_SOF_EN
  logic             in_sof;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIN_W-1:0] p0, p1, p2, p3, p5, p6, p7, p8;

  modport slave (
    input  in_valid, in_pixel,
`ifdef SOBEL_WIN_SOF_EN
    input  in_sof,
`endif
    input  out_ready,
    output in_ready, out_valid,
    output p0, p1, p2, p3, p5, p6, p7, p8
  );

  modport master (
    output in_valid, in_pixel,
`ifdef SOBEL_WIN_SOF_EN
    output in_sof,
`endif
    output out_ready,
    input  in_ready, out_valid,
    input  p0, p1, p2, p3, p5, p6, p7, p8
  );

endinterface

// File: rtl/sobel_line_mem.sv
// One image line of pixels: combinational read, synchronous write.
// A same-address write returns the old word on the read port in that cycle.
module sobel_line_mem
  import sobel_win_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [IMG_W];

  assign rdata = mem[addr];

  // No reset: rows 0..1 never emit, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_3x3.sv
// Streaming 3x3 neighbourhood generator; emits only interior-complete windows.
// Optional SOBEL_WIN_SOF_EN adds in_sof to realign the frame on any accept.
module sobel_window_3x3
  import sobel_win_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic        clk,
  input logic        rst,
  sobel_win_if.slave bus
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);

  logic [COL_W-1:0] col_q, cur_col, col_next;
  logic [ROW_W-1:0] row_q, cur_row, row_next;
  logic             accept, sof_hit, has_win;
  logic             out_valid_q;
  logic [PIX_W-1:0] l1_rd, l2_rd;
  // index 2 = column x, 1 = x-1, 0 = x-2
  logic [2:0][PIX_W-1:0] top_q, mid_q, bot_q;
  win_t             win_next, win_q;

  assign bus.in_ready = bus.out_ready | ~out_valid_q;
  assign accept       = bus.in_valid & bus.in_ready;

`ifdef SOBEL_WIN_SOF_EN
  assign sof_hit = bus.in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // Position of the pixel on the bus right now; SOF forces it to (0,0).
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (sof_hit) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  always_comb begin
    col_next = cur_col + COL_W'(1);
    row_next = cur_row;
    if (cur_col == COL_W'(IMG_W - 1)) begin
      col_next = '0;
      row_next = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
    end
  end

  assign has_win = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

  sobel_line_mem #(.IMG_W(IMG_W), .ADDR_W(COL_W)) u_l1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (bus.in_pixel),
    .rdata (l1_rd)
  );

  sobel_line_mem #(.IMG_W(IMG_W), .ADDR_W(COL_W)) u_l2 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (l1_rd),
    .rdata (l2_rd)
  );

  // Window as it will look after this accept's shift.
  always_comb begin
    win_next    = '0;
    win_next.p0 = {1'b0, top_q[1]};
    win_next.p1 = {1'b0, top_q[2]};
    win_next.p2 = {1'b0, l2_rd};
    win_next.p3 = {1'b0, mid_q[1]};
    win_next.p5 = {1'b0, l1_rd};
    win_next.p6 = {1'b0, bot_q[1]};
    win_next.p7 = {1'b0, bot_q[2]};
    win_next.p8 = {1'b0, bus.in_pixel};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (accept) begin
      col_q <= col_next;
      row_q <= row_next;
      top_q <= {l2_rd, top_q[2], top_q[1]};
      mid_q <= {l1_rd, mid_q[2], mid_q[1]};
      bot_q <= {bus.in_pixel, bot_q[2], bot_q[1]};
    end
  end

  // Single output register; accept implies out_ready or empty, so no loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      win_q       <= '0;
    end else if (accept && has_win) begin
      out_valid_q <= 1'b1;
      win_q       <= win_next;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p0 = win_q.p0;
  assign bus.p1 = win_q.p1;
  assign bus.p2 = win_q.p2;
  assign bus.p3 = win_q.p3;
  assign bus.p5 = win_q.p5;
  assign bus.p6 = win_q.p6;
  assign bus.p7 = win_q.p7;
  assign bus.p8 = win_q.p8;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Self-checking bench for sobel_window_3x3 on a 5x4 image, pixel = 10*row+col.
// Defining SOBEL_WIN_SOF_EN also exercises the in_sof realignment.
module tb_sobel_window_3x3;
  import sobel_win_pkg::*;

  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int WB    = $bits(win_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_win_if bus ();

  sobel_window_3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [WB-1:0] exp_q[$];
  logic [WB-1:0] recv_q[$];

  // Image-level model: remember the frame, cut windows out of it.
  int         m_row, m_col;
  logic [7:0] img [IMG_H][IMG_W];

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] mk_win(input int a0, a1, a2, a3, a5, a6, a7, a8);
    win_t w;
    w.p0 = WIN_W'(a0); w.p1 = WIN_W'(a1); w.p2 = WIN_W'(a2); w.p3 = WIN_W'(a3);
    w.p5 = WIN_W'(a5); w.p6 = WIN_W'(a6); w.p7 = WIN_W'(a7); w.p8 = WIN_W'(a8);
    return w;
  endfunction

  function automatic logic [WB-1:0] bus_win();
    win_t w;
    w.p0 = bus.p0; w.p1 = bus.p1; w.p2 = bus.p2; w.p3 = bus.p3;
    w.p5 = bus.p5; w.p6 = bus.p6; w.p7 = bus.p7; w.p8 = bus.p8;
    return w;
  endfunction

  function automatic void model_reset();
    m_row = 0;
    m_col = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input logic [7:0] pix, input logic sof);
    int r, c;
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    r = m_row;
    c = m_col;
    img[r][c] = pix;
    if (r >= 2 && c >= 2)
      exp_q.push_back(mk_win(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                             img[r-1][c-2], img[r-1][c],
                             img[r][c-2],   img[r][c-1],   img[r][c]));
    m_col = (c == IMG_W - 1) ? 0 : c + 1;
    if (c == IMG_W - 1) m_row = (r == IMG_H - 1) ? 0 : r + 1;
  endfunction

  // Scoreboard: every transferred window against the model, stalls held.
  logic          stall_prev = 1'b0;
  logic [WB-1:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", bus_win(), held);
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", WB'(bus.in_ready), WB'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_window: got %h expected none", bus_win());
        end else begin
          check("window", bus_win(), exp_q.pop_front());
        end
        recv_q.push_back(bus_win());
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus_win();
    end
  end

  task automatic send(input logic [7:0] pix, input logic sof, input int gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof = sof;
`endif
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(pix, sof);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        break;
      end
    end
    bus.in_valid = 1'b0;
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof = 1'b0;
`endif
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int gap_max);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        send(8'(10*r + c), 1'b0, $urandom_range(0, gap_max));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    repeat (2) begin @(posedge clk); #1; end
    check("drain_empty", WB'(exp_q.size()), WB'(0));
  endtask

  task automatic check_frame(input string tag, input int base);
    check({tag, "_first"}, recv_q[base], mk_win(0, 1, 2, 10, 12, 20, 21, 22));
    check({tag, "_last_p8"}, WB'(recv_q[base+5][WIN_W-1:0]), WB'(34));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b0;
`ifdef SOBEL_WIN_SOF_EN
    bus.in_sof = 1'b0;
`endif
    // 1: reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", WB'(bus.out_valid), WB'(0));
    check("rst_window", bus_win(), '0);
    check("rst_in_ready", WB'(bus.in_ready), WB'(1));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // 2: one frame, latency of the first window
    recv_q.delete();
    for (int i = 0; i < IMG_W*IMG_H; i++) begin
      send(8'(10*(i/IMG_W) + i%IMG_W), 1'b0, 0);
      if (i == 11) check("no_early_valid", WB'(bus.out_valid), WB'(0));
      if (i == 12) check("first_latency", WB'(bus.out_valid), WB'(1));
    end
    drain();
    check("t2_count", WB'(recv_q.size()), WB'(6));
    if (recv_q.size() == 6) check_frame("t2", 0);

    // 3: three-cycle downstream stall
    recv_q.delete();
    fork
      send_frame(0);
      begin
        int n = 0;
        while (n < 500) begin
          @(negedge clk);
          if (bus.out_valid) break;
          n++;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("t3_count", WB'(recv_q.size()), WB'(6));
    if (recv_q.size() == 6) check_frame("t3", 0);

    // 4: two frames with random input gaps
    recv_q.delete();
    send_frame(2);
    send_frame(2);
    drain();
    check("t4_count", WB'(recv_q.size()), WB'(12));
    if (recv_q.size() == 12) begin
      check_frame("t4a", 0);
      check_frame("t4b", 6);
    end

    // 5: reset after 8 pixels
    for (int i = 0; i < 8; i++) send(8'(10*(i/IMG_W) + i%IMG_W), 1'b0, 0);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", WB'(bus.out_valid), WB'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    recv_q.delete();
    send_frame(0);
    drain();
    check("t5_count", WB'(recv_q.size()), WB'(6));
    if (recv_q.size() == 6) check_frame("t5", 0);

`ifdef SOBEL_WIN_SOF_EN
    // 6: in_sof on the 4th pixel realigns the frame
    recv_q.delete();
    for (int i = 0; i < 3; i++) send(8'(i), 1'b0, 0);
    for (int i = 0; i < IMG_W*IMG_H; i++) begin
      send(8'(10*(i/IMG_W) + i%IMG_W), (i == 0), 0);
      if (i == 11) check("sof_no_early", WB'(bus.out_valid), WB'(0));
      if (i == 12) check("sof_latency", WB'(bus.out_valid), WB'(1));
    end
    drain();
    check("t6_count", WB'(recv_q.size()), WB'(6));
    if (recv_q.size() == 6) check_frame("t6", 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
